// File: rtl/lin_app_pkg.sv
// Shared definitions for the multi-slave LIN application layer:
// FSM encoding, frame-type codes and parameter defaults.
package lin_app_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OPER    = 3'd1,
    ST_SLEEP   = 3'd2,
    ST_DIAG_RX = 3'd3,
    ST_DIAG_TX = 3'd4
  } state_t;

  localparam logic [1:0] FT_UNCOND = 2'd0;
  localparam logic [1:0] FT_DIAG   = 2'd1;
  localparam logic [1:0] FT_EVENT  = 2'd2;

  localparam int DEF_NUM_SLAVES = 2;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_INIT_DEPTH = 2;
  localparam int DEF_NAD_W      = 4;
  localparam int DEF_NAD_BASE   = 1;
  localparam int DEF_DIAG_LEN   = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lin_evt_writer.sv
// Per-slave memory port: init word writes, event-frame change detection
// and the multi-word write-back burst of the new signal value.
module lin_evt_writer
  import lin_app_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_wr,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [WORD_W-1:0] init_wdata,
  input  logic              evt_start,
  input  logic              abort,
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              updated,
  output logic              busy
);

  localparam int WPF   = DATA_W / WORD_W;
  localparam int IDX_W = (WPF > 1) ? $clog2(WPF) : 1;

  logic [WPF-1:0][WORD_W-1:0] cap_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       active_q;
  logic                       last_q;
  logic                       changed;

  assign changed = (old_data != new_data);
  assign busy    = active_q;

  // Word 0 goes out with the compare; the rest come from a captured copy
  // so the source may change while the burst is still running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      updated   <= 1'b0;
      cap_q     <= '0;
      idx_q     <= '0;
      active_q  <= 1'b0;
      last_q    <= 1'b0;
    end else if (abort) begin
      mem_we   <= 1'b0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else if (init_wr) begin
      mem_we    <= 1'b1;
      mem_addr  <= init_addr;
      mem_wdata <= init_wdata;
    end else if (evt_start) begin
      updated <= changed;
      mem_we  <= changed;
      if (changed) begin
        mem_addr  <= '0;
        mem_wdata <= new_data[WORD_W-1:0];
        cap_q     <= new_data;
        idx_q     <= IDX_W'(1);
        last_q    <= (WPF == 1);
        active_q  <= 1'b1;
      end
    end else if (active_q && !last_q) begin
      mem_we    <= 1'b1;
      mem_addr  <= ADDR_W'(idx_q);
      mem_wdata <= cap_q[idx_q];
      last_q    <= (idx_q == IDX_W'(WPF - 1));
      idx_q     <= idx_q + 1'b1;
    end else begin
      mem_we   <= 1'b0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end
  end

endmodule

// File: rtl/lin_app_layer_multi.sv
// LIN slave application layer serving several logical slaves: init copy,
// event-triggered write-back, diagnostic sequencing and sleep/wake.
module lin_app_layer_multi
  import lin_app_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INIT_DEPTH = DEF_INIT_DEPTH,
  parameter int NAD_W      = DEF_NAD_W,
  parameter int NAD_BASE   = DEF_NAD_BASE,
  parameter int DIAG_LEN   = DEF_DIAG_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init_start,
  input  logic                         init_finish,
  input  logic                         sleep_cmd,
  input  logic                         wakeup,
  input  logic                         frame_valid,
  input  logic [1:0]                   frame_type,
  input  logic                         master_publisher,
  input  logic [NAD_W-1:0]             diag_nad,
  input  logic [NUM_SLAVES*WORD_W-1:0] init_rdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] old_data,
  input  logic [NUM_SLAVES*DATA_W-1:0] new_data,
  output logic [NUM_SLAVES-1:0]        mem_we,
  output logic [NUM_SLAVES*ADDR_W-1:0] mem_addr,
  output logic [NUM_SLAVES*WORD_W-1:0] mem_wdata,
  output logic [NUM_SLAVES-1:0]        updated,
  output logic                         diag_valid,
  output logic [2:0]                   diag_idx,
  output logic                         diag_tx,
  output logic [2:0]                   state
);

  localparam int CNT_W = $clog2(max2(INIT_DEPTH, DIAG_LEN) + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diag_valid_q, diag_valid_d;
  logic [2:0]       diag_idx_q, diag_idx_d;
  logic             diag_tx_q;
  logic             init_wr, evt_start, abort;
  logic [NUM_SLAVES-1:0] busy;
  logic [ADDR_W-1:0] init_addr;
  logic [31:0]      nad_off;
  logic             nad_hit;
  logic             unused_in;

  // Unsigned offset: NADs below the base wrap to a large value and miss.
  assign nad_off   = 32'(diag_nad) - 32'(NAD_BASE);
  assign nad_hit   = (nad_off < 32'(NUM_SLAVES));
  assign init_addr = ADDR_W'(cnt_q);
  assign unused_in = master_publisher;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    diag_valid_d = diag_valid_q;
    diag_idx_d   = diag_idx_q;
    init_wr      = 1'b0;
    evt_start    = 1'b0;
    abort        = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (init_start && init_finish) begin
          state_d = ST_OPER;
          cnt_d   = '0;
        end else if (init_start && (cnt_q < CNT_W'(INIT_DEPTH))) begin
          init_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_OPER: begin
        if (sleep_cmd) begin
          state_d = ST_SLEEP;
          abort   = 1'b1;
        end else if (frame_valid && (busy == '0)) begin
          case (frame_type)
            FT_DIAG: begin
              if (nad_hit) begin
                diag_valid_d = 1'b1;
                diag_idx_d   = nad_off[2:0];
                state_d      = ST_DIAG_RX;
                cnt_d        = '0;
              end else begin
                diag_valid_d = 1'b0;
              end
            end
            FT_EVENT:  evt_start = 1'b1;
            FT_UNCOND: ;
            default:   ;
          endcase
        end
      end
      ST_DIAG_RX: begin
        if (cnt_q == CNT_W'(DIAG_LEN - 1)) begin
          state_d = ST_DIAG_TX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIAG_TX: begin
        if (cnt_q == CNT_W'(DIAG_LEN - 1)) begin
          state_d      = ST_OPER;
          cnt_d        = '0;
          diag_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SLEEP: begin
        if (wakeup) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      diag_valid_q <= 1'b0;
      diag_idx_q   <= '0;
      diag_tx_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      diag_valid_q <= diag_valid_d;
      diag_idx_q   <= diag_idx_d;
      diag_tx_q    <= (state_d == ST_DIAG_TX);
    end
  end

  assign state      = state_q;
  assign diag_valid = diag_valid_q;
  assign diag_idx   = diag_idx_q;
  assign diag_tx    = diag_tx_q;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
    lin_evt_writer #(
      .DATA_W (DATA_W),
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
    ) u_writer (
      .clk        (clk),
      .reset      (reset),
      .init_wr    (init_wr),
      .init_addr  (init_addr),
      .init_wdata (init_rdata[i*WORD_W +: WORD_W]),
      .evt_start  (evt_start),
      .abort      (abort),
      .old_data   (old_data[i*DATA_W +: DATA_W]),
      .new_data   (new_data[i*DATA_W +: DATA_W]),
      .mem_we     (mem_we[i]),
      .mem_addr   (mem_addr[i*ADDR_W +: ADDR_W]),
      .mem_wdata  (mem_wdata[i*WORD_W +: WORD_W]),
      .updated    (updated[i]),
      .busy       (busy[i])
    );
  end

endmodule
